// File: rtl/pipe_pkg.sv
// Shared types and width constants for the pipeline's memory stage.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory handshake controller: alignment check, req/ack FSM and stall generation.
module dmem_ctrl
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic       op_read,
    input  logic       op_write,
    input  logic [1:0] addr_lsb,
    input  logic       dmem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       mem_stall,
    output logic       mem_align_err,
    output logic       complete
);

    mem_state_t state_q, state_d;

    logic mem_op;
    logic misaligned;
    logic aligned_op;

    assign mem_op     = op_valid & (op_read | op_write);
    assign misaligned = (addr_lsb != 2'b00);
    assign aligned_op = mem_op & ~misaligned;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        dmem_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                dmem_req = aligned_op;
                if (aligned_op && !dmem_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A store wins when both control bits are set; acks without a request never complete.
    assign dmem_we       = op_write;
    assign complete      = dmem_req & dmem_ack;
    assign mem_stall     = dmem_req & ~dmem_ack;
    assign mem_align_err = mem_op & misaligned;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory access, MEM/WB register and stall counter.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [WORD_W-1:0]     ex_alu_result,
    input  logic [WORD_W-1:0]     ex_write_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_to_reg,
    output logic                  mem_stall,
    output logic [WORD_W-1:0]     EX_MEM_alu_result,
    output logic [REG_ADDR_W-1:0] ex_mem_rd,
    output logic                  ex_mem_reg_write,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [WORD_W-1:0]     dmem_rdata,
    output logic                  mem_wb_valid,
    output logic [WORD_W-1:0]     MEM_WB_read_data,
    output logic [WORD_W-1:0]     MEM_WB_alu_result,
    output logic [REG_ADDR_W-1:0] mem_wb_rd,
    output logic                  mem_wb_reg_write,
    output logic                  mem_wb_mem_to_reg,
    output logic                  mem_align_err,
    output logic [31:0]           stall_cycles
);

    logic                  ex_valid_q;
    logic [WORD_W-1:0]     ex_alu_q;
    logic [WORD_W-1:0]     ex_wdata_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  ex_mem_read_q;
    logic                  ex_mem_write_q;
    logic                  ex_reg_write_q;
    logic                  ex_mem_to_reg_q;

    logic                  wb_valid_q;
    logic [WORD_W-1:0]     wb_read_data_q;
    logic [WORD_W-1:0]     wb_alu_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic                  wb_reg_write_q;
    logic                  wb_mem_to_reg_q;

    logic [31:0]           stall_cnt_q;
    logic                  complete;
    logic                  is_load;

    dmem_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (ex_valid_q),
        .op_read       (ex_mem_read_q),
        .op_write      (ex_mem_write_q),
        .addr_lsb      (ex_alu_q[1:0]),
        .dmem_ack      (dmem_ack),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .mem_stall     (mem_stall),
        .mem_align_err (mem_align_err),
        .complete      (complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q      <= 1'b0;
            ex_alu_q        <= '0;
            ex_wdata_q      <= '0;
            ex_rd_q         <= '0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
        end else if (!mem_stall) begin
            ex_valid_q      <= ex_valid;
            ex_alu_q        <= ex_alu_result;
            ex_wdata_q      <= ex_write_data;
            ex_rd_q         <= ex_rd;
            ex_mem_read_q   <= ex_mem_read;
            ex_mem_write_q  <= ex_mem_write;
            ex_reg_write_q  <= ex_reg_write;
            ex_mem_to_reg_q <= ex_mem_to_reg;
        end
    end

    assign is_load = ex_mem_read_q & ~ex_mem_write_q;

    // Stalled and misaligned instructions both retire as bubbles; data fields keep their last values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q      <= 1'b0;
            wb_read_data_q  <= '0;
            wb_alu_q        <= '0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
        end else if (mem_stall || mem_align_err) begin
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
        end else begin
            wb_valid_q      <= ex_valid_q;
            wb_alu_q        <= ex_alu_q;
            wb_rd_q         <= ex_rd_q;
            wb_reg_write_q  <= ex_valid_q & ex_reg_write_q;
            wb_mem_to_reg_q <= ex_mem_to_reg_q;
            if (complete && is_load) begin
                wb_read_data_q <= dmem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (mem_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign EX_MEM_alu_result = ex_alu_q;
    assign ex_mem_rd         = ex_rd_q;
    assign ex_mem_reg_write  = ex_valid_q & ex_reg_write_q;
    assign dmem_addr         = ADDR_W'(ex_alu_q);
    assign dmem_wdata        = ex_wdata_q;

    assign mem_wb_valid      = wb_valid_q;
    assign MEM_WB_read_data  = wb_read_data_q;
    assign MEM_WB_alu_result = wb_alu_q;
    assign mem_wb_rd         = wb_rd_q;
    assign mem_wb_reg_write  = wb_reg_write_q;
    assign mem_wb_mem_to_reg = wb_mem_to_reg_q;
    assign stall_cycles      = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, handshake sequences and a randomized program run.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_write_data;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic        mem_stall;
    logic [31:0] EX_MEM_alu_result;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_write;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_wb_valid;
    logic [31:0] MEM_WB_read_data, MEM_WB_alu_result;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_reg_write, mem_wb_mem_to_reg;
    logic        mem_align_err;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .ex_alu_result     (ex_alu_result),
        .ex_write_data     (ex_write_data),
        .ex_rd             (ex_rd),
        .ex_mem_read       (ex_mem_read),
        .ex_mem_write      (ex_mem_write),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_to_reg     (ex_mem_to_reg),
        .mem_stall         (mem_stall),
        .EX_MEM_alu_result (EX_MEM_alu_result),
        .ex_mem_rd         (ex_mem_rd),
        .ex_mem_reg_write  (ex_mem_reg_write),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .mem_wb_valid      (mem_wb_valid),
        .MEM_WB_read_data  (MEM_WB_read_data),
        .MEM_WB_alu_result (MEM_WB_alu_result),
        .mem_wb_rd         (mem_wb_rd),
        .mem_wb_reg_write  (mem_wb_reg_write),
        .mem_wb_mem_to_reg (mem_wb_mem_to_reg),
        .mem_align_err     (mem_align_err),
        .stall_cycles      (stall_cycles)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic mr, input logic mw,
                         input logic rw, input logic m2r);
        ex_valid = v; ex_alu_result = alu; ex_write_data = wd; ex_rd = rd;
        ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw; ex_mem_to_reg = m2r;
    endtask

    task automatic idle_in();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mr, mw, rw, m2r;
        logic        exp_wb_valid, exp_wb_rw, exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw, m2r;
        logic [31:0] rdata;
    } ret_t;

    typedef struct {
        int          lat;
        logic [31:0] addr;
        logic        we;
    } acc_t;

    vec_t        vecs[6];
    logic [31:0] ref_mem[16];
    logic [31:0] dev_mem[16];
    ret_t        ret_q[$];
    acc_t        acc_q[$];
    ret_t        r;
    acc_t        a;

    localparam int N_RAND = 300;

    initial begin
        int          idx, drain, cyc, wait_left, stall_exp, err_exp, err_cnt, kind;
        bit          accepted, in_req;
        logic [31:0] last_rd, req_addr, alu, wd;
        logic        req_we, v, mr, mw, rw, m2r, mis;
        logic [3:0]  w;

        vecs[0] = '{1'b1, 32'h0000_0010, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFF0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0102, 5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0203, 5'd9,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0301, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0105, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset with a live instruction on the inputs: reset must win.
        reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
        drive(1'b1, 32'h0000_0400, 32'h1111_1111, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        step(); step();
        idle_in();
        reset = 1'b0;
        check("rst_mem_stall", mem_stall, 0);
        check("rst_ex_mem_alu", EX_MEM_alu_result, 0);
        check("rst_ex_mem_rd", ex_mem_rd, 0);
        check("rst_ex_mem_rw", ex_mem_reg_write, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_dmem_addr", dmem_addr, 0);
        check("rst_dmem_wdata", dmem_wdata, 0);
        check("rst_wb_valid", mem_wb_valid, 0);
        check("rst_wb_rdata", MEM_WB_read_data, 0);
        check("rst_wb_alu", MEM_WB_alu_result, 0);
        check("rst_wb_rd", mem_wb_rd, 0);
        check("rst_wb_rw", mem_wb_reg_write, 0);
        check("rst_wb_m2r", mem_wb_mem_to_reg, 0);
        check("rst_align_err", mem_align_err, 0);
        check("rst_stall_cycles", stall_cycles, 0);

        // Single-instruction vectors: pass-through, misaligned and invalid.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, vecs[i].alu, $urandom, vecs[i].rd,
                  vecs[i].mr, vecs[i].mw, vecs[i].rw, vecs[i].m2r);
            step();
            check($sformatf("vec%0d_ex_mem_alu", i), EX_MEM_alu_result, vecs[i].alu);
            check($sformatf("vec%0d_align_err", i), mem_align_err, vecs[i].exp_err);
            check($sformatf("vec%0d_req", i), dmem_req, 0);
            check($sformatf("vec%0d_stall", i), mem_stall, 0);
            if (vecs[i].valid) begin
                check($sformatf("vec%0d_ex_mem_rd", i), ex_mem_rd, vecs[i].rd);
                check($sformatf("vec%0d_ex_mem_rw", i), ex_mem_reg_write, vecs[i].rw);
            end
            idle_in();
            step();
            check($sformatf("vec%0d_wb_valid", i), mem_wb_valid, vecs[i].exp_wb_valid);
            check($sformatf("vec%0d_wb_rw", i), mem_wb_reg_write, vecs[i].exp_wb_rw);
            check($sformatf("vec%0d_err_drop", i), mem_align_err, 0);
            if (vecs[i].exp_wb_valid) begin
                check($sformatf("vec%0d_wb_rd", i), mem_wb_rd, vecs[i].rd);
                check($sformatf("vec%0d_wb_alu", i), MEM_WB_alu_result, vecs[i].alu);
            end
        end

        // Load with three wait cycles; the following add must be held out.
        drive(1'b1, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'h0000_0044, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lw_wait%0d_req", k), dmem_req, 1);
            check($sformatf("lw_wait%0d_stall", k), mem_stall, 1);
            check($sformatf("lw_wait%0d_addr", k), dmem_addr, 32'h0000_0100);
            check($sformatf("lw_wait%0d_we", k), dmem_we, 0);
            check($sformatf("lw_wait%0d_ex_mem", k), EX_MEM_alu_result, 32'h0000_0100);
            if (k > 0) check($sformatf("lw_wait%0d_bubble", k), mem_wb_valid, 0);
            step();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("lw_ack_stall", mem_stall, 0);
        check("lw_ack_req", dmem_req, 1);
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        check("lw_wb_valid", mem_wb_valid, 1);
        check("lw_wb_rdata", MEM_WB_read_data, 32'hDEAD_BEEF);
        check("lw_wb_m2r", mem_wb_mem_to_reg, 1);
        check("lw_wb_rd", mem_wb_rd, 7);
        check("lw_stall_cycles", stall_cycles, 3);
        check("lw_next_entered", EX_MEM_alu_result, 32'h0000_0044);
        idle_in();
        step();
        check("add_after_lw_valid", mem_wb_valid, 1);
        check("add_after_lw_rd", mem_wb_rd, 9);
        check("add_after_lw_rdata_hold", MEM_WB_read_data, 32'hDEAD_BEEF);

        // Zero-wait store: acked in the request cycle, next instruction enters on the next edge.
        drive(1'b1, 32'h0000_0200, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        dmem_ack = 1'b1;
        drive(1'b1, 32'h0000_0055, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("sw_req", dmem_req, 1);
        check("sw_we", dmem_we, 1);
        check("sw_addr", dmem_addr, 32'h0000_0200);
        check("sw_wdata", dmem_wdata, 32'h1234_5678);
        check("sw_stall", mem_stall, 0);
        step();
        dmem_ack = 1'b0;
        idle_in();
        check("sw_next_entered", EX_MEM_alu_result, 32'h0000_0055);
        check("sw_req_single", dmem_req, 0);
        check("sw_wb_valid", mem_wb_valid, 1);
        check("sw_wb_rw", mem_wb_reg_write, 0);
        check("sw_stall_cycles", stall_cycles, 3);
        step();

        // Back-to-back zero-wait load then store: req stays high across the boundary.
        drive(1'b1, 32'h0000_0300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_5A5A;
        drive(1'b1, 32'h0000_0304, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("b2b_req0", dmem_req, 1);
        check("b2b_addr0", dmem_addr, 32'h0000_0300);
        step();
        dmem_rdata = 32'h0;
        check("b2b_req1", dmem_req, 1);
        check("b2b_addr1", dmem_addr, 32'h0000_0304);
        check("b2b_we1", dmem_we, 1);
        check("b2b_wdata1", dmem_wdata, 32'hCAFE_F00D);
        check("b2b_lw_rdata", MEM_WB_read_data, 32'hA5A5_5A5A);
        idle_in();
        step();
        dmem_ack = 1'b0;
        check("b2b_req_drop", dmem_req, 0);
        check("b2b_sw_valid", mem_wb_valid, 1);
        check("b2b_sw_rdata_hold", MEM_WB_read_data, 32'hA5A5_5A5A);

        // Reset during the second wait cycle of a load, then a late ack.
        drive(1'b1, 32'h0000_0400, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        idle_in();
        step();
        check("rma_stall_before", mem_stall, 1);
        check("rma_count_before", stall_cycles, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rma_req", dmem_req, 0);
        check("rma_stall", mem_stall, 0);
        check("rma_stall_cycles", stall_cycles, 0);
        check("rma_wb_valid", mem_wb_valid, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
        #1;
        check("rma_late_ack_req", dmem_req, 0);
        check("rma_late_ack_stall", mem_stall, 0);
        step();
        dmem_ack = 1'b0;
        check("rma_late_ack_wb_valid", mem_wb_valid, 0);
        check("rma_late_ack_rdata", MEM_WB_read_data, 0);

        // Randomized program against a program-order reference model and a random-latency memory.
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            dev_mem[i] = ref_mem[i];
        end
        idx = 0; drain = 0; cyc = 0; wait_left = 0; stall_exp = 0;
        err_exp = 0; err_cnt = 0; accepted = 1'b1; in_req = 1'b0;
        last_rd = 32'h0; req_addr = 32'h0; req_we = 1'b0;
        while (idx < N_RAND || drain < 8) begin
            if (mem_wb_valid) begin
                if (ret_q.size() == 0) begin
                    check("rand_extra_retire", 1, 0);
                end else begin
                    r = ret_q.pop_front();
                    check("rand_wb_alu", MEM_WB_alu_result, r.alu);
                    check("rand_wb_rd", mem_wb_rd, r.rd);
                    check("rand_wb_rw", mem_wb_reg_write, r.rw);
                    check("rand_wb_m2r", mem_wb_mem_to_reg, r.m2r);
                    check("rand_wb_rdata", MEM_WB_read_data, r.rdata);
                end
            end else begin
                check("rand_bubble_rw", mem_wb_reg_write, 0);
            end

            if (accepted) begin
                if (idx < N_RAND) begin
                    kind = $urandom_range(0, 9);
                    w = 4'($urandom_range(0, 15));
                    wd = $urandom;
                    v = 1'b1; mr = 1'b0; mw = 1'b0; rw = 1'($urandom); m2r = 1'b0;
                    alu = {26'h0, w, 2'b00};
                    case (kind)
                        0, 1, 2: alu = $urandom;
                        3, 4:    begin mr = 1'b1; rw = 1'b1; m2r = 1'b1; end
                        5, 6:    begin mw = 1'b1; rw = 1'b0; end
                        7:       begin mr = 1'b1; mw = 1'b1; m2r = 1'($urandom); end
                        8: begin
                            if ($urandom_range(0, 1) == 0) mr = 1'b1; else mw = 1'b1;
                            alu = {26'h0, w, 2'($urandom_range(1, 3))};
                        end
                        default: begin
                            v = 1'b0; rw = 1'b0; mr = 1'($urandom); mw = 1'($urandom);
                            alu = $urandom;
                        end
                    endcase
                    drive(v, alu, wd, 5'($urandom), mr, mw, rw, m2r);
                    mis = (mr || mw) && (alu[1:0] != 2'b00);
                    if (v && mis) begin
                        err_exp++;
                    end else if (v) begin
                        if (mr || mw) begin
                            a.lat = $urandom_range(0, 3);
                            a.addr = alu;
                            a.we = mw;
                            acc_q.push_back(a);
                            stall_exp += a.lat;
                            if (mw) ref_mem[alu[5:2]] = wd;
                            else    last_rd = ref_mem[alu[5:2]];
                        end
                        r.alu = alu; r.rd = ex_rd; r.rw = rw; r.m2r = m2r; r.rdata = last_rd;
                        ret_q.push_back(r);
                    end
                    idx++;
                end else begin
                    idle_in();
                end
            end

            if (dmem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    req_addr = dmem_addr;
                    req_we = dmem_we;
                    if (acc_q.size() == 0) begin
                        check("rand_spurious_req", 1, 0);
                        wait_left = 0;
                    end else begin
                        a = acc_q.pop_front();
                        wait_left = a.lat;
                        check("rand_req_addr", dmem_addr, a.addr);
                        check("rand_req_we", dmem_we, a.we);
                    end
                end else begin
                    check("rand_addr_stable", dmem_addr, req_addr);
                    check("rand_we_stable", dmem_we, req_we);
                end
                if (wait_left == 0) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = dev_mem[dmem_addr[5:2]];
                    if (dmem_we) dev_mem[dmem_addr[5:2]] = dmem_wdata;
                    in_req = 1'b0;
                end else begin
                    dmem_ack = 1'b0;
                    dmem_rdata = $urandom;
                    wait_left--;
                end
            end else begin
                in_req = 1'b0;
                dmem_ack = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end

            #1;
            if (mem_align_err) err_cnt++;
            accepted = !mem_stall;
            step();
            if (idx >= N_RAND) drain++;
            cyc++;
            if (cyc > 20000) begin
                check("rand_timeout", 1, 0);
                break;
            end
        end
        dmem_ack = 1'b0;
        check("rand_all_retired", ret_q.size(), 0);
        check("rand_all_accessed", acc_q.size(), 0);
        check("rand_stall_cycles", stall_cycles, stall_exp);
        check("rand_align_errs", err_cnt, err_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
